alu_issue: RTL

- Front end that drives the single-cycle registered ALU datapath (op/rs1/rs2/bitimm in, rd/overflow out).
- Accepts one RV32 instruction at a time over a valid/ready handshake and decodes it to the datapath's 4-bit op.
- Reads operands from an internal 32x32 register file, presents them to the datapath, and writes the registered result back.
- Sits between instruction fetch and the datapath; it owns the architectural register file.

---
 rtl/alu_issue.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
//
// Issue front end for the single-cycle registered ALU datapath. Accepts one
// RV32 instruction at a time over a valid/ready handshake, decodes it to the
// datapath's 4-bit op, reads operands from the architectural register file
// held here, presents them to the datapath and writes the result back.
// Instructions are strictly serialized: IDLE -> EXEC -> WB -> IDLE.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   inst_valid, inst    instruction offer (RV32 word)
//   inst_ready          high only in IDLE while out of reset
//   dp_op/rs1/rs2/bitimm  registered datapath inputs (op=IDLE_OP when idle)
//   dp_rd, dp_overflow  datapath result and carry/borrow, valid in WB
//   retire_valid/rd_addr/data  one-cycle write-back report
//   illegal             one-cycle pulse for a dropped, unsupported encoding
//   ovf_sticky, ovf_clr sticky ADD/SUB carry flag and its synchronous clear
//   dbg_addr, dbg_data  combinational register-file debug read port
// ---------------------------------------------------------------------------
module alu_issue #(
    parameter int         XLEN    = 32,
    parameter logic [3:0] IDLE_OP = 4'b1111
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inst_valid,
    input  logic [31:0]     inst,
    output logic            inst_ready,
    output logic [3:0]      dp_op,
    output logic [XLEN-1:0] dp_rs1,
    output logic [XLEN-1:0] dp_rs2,
    output logic [19:0]     dp_bitimm,
    input  logic [XLEN-1:0] dp_rd,
    input  logic            dp_overflow,
    output logic            retire_valid,
    output logic [4:0]      retire_rd_addr,
    output logic [XLEN-1:0] retire_data,
    output logic            illegal,
    output logic            ovf_sticky,
    input  logic            ovf_clr,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    // Datapath op encodings
    localparam logic [3:0] OP_SLL  = 4'b0000;
    localparam logic [3:0] OP_SRL  = 4'b0001;
    localparam logic [3:0] OP_SRA  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_LUI  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_AND  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t state;

    // Architectural register file; entry 0 is never written and stays zero.
    logic [XLEN-1:0] rf [32];

    // Destination and ADD/SUB flag carried from accept through write-back
    logic [4:0] wb_addr_p1;
    logic       addsub_p1;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1_a;
    logic [4:0] rs2_a;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rs1_a  = inst[19:15];
    assign rs2_a  = inst[24:20];

    // Sign-extend a 12-bit I-type immediate to the register width.
    function automatic logic signed [XLEN-1:0] sext12(input logic signed [11:0] imm);
        return XLEN'(imm);
    endfunction

    // The datapath shifts by the whole rs2 value, so only the 5-bit shift
    // amount may reach it.
    function automatic logic [XLEN-1:0] mask_shamt(input logic [XLEN-1:0] v);
        return {{(XLEN-5){1'b0}}, v[4:0]};
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // -----------------------------------------------------------------------
    // Decode (combinational, consumed at the IDLE accept edge)
    // -----------------------------------------------------------------------
    logic            dec_legal;
    logic [3:0]      dec_op;
    logic [XLEN-1:0] dec_rs1;
    logic [XLEN-1:0] dec_rs2;
    logic [XLEN-1:0] dec_rs2_m;
    logic [19:0]     dec_bitimm;

    always_comb begin
        dec_legal  = 1'b0;
        dec_op     = IDLE_OP;
        dec_rs1    = '0;
        dec_rs2    = '0;
        dec_bitimm = '0;
        case (opcode)
            OPC_R: begin
                dec_rs1   = rf[rs1_a];
                dec_rs2   = rf[rs2_a];
                dec_legal = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, 3'b001}: dec_op = OP_SLL;
                    {F7_BASE, 3'b101}: dec_op = OP_SRL;
                    {F7_ALT,  3'b101}: dec_op = OP_SRA;
                    {F7_BASE, 3'b000}: dec_op = OP_ADD;
                    {F7_ALT,  3'b000}: dec_op = OP_SUB;
                    {F7_BASE, 3'b010}: dec_op = OP_SLT;
                    {F7_BASE, 3'b011}: dec_op = OP_SLTU;
                    {F7_BASE, 3'b100}: dec_op = OP_XOR;
                    {F7_BASE, 3'b110}: dec_op = OP_OR;
                    {F7_BASE, 3'b111}: dec_op = OP_AND;
                    {F7_MUL,  3'b000}: dec_op = OP_MUL;
                    default: begin
                        dec_legal = 1'b0;
                        dec_op    = IDLE_OP;
                    end
                endcase
            end
            OPC_I: begin
                dec_rs1   = rf[rs1_a];
                dec_rs2   = sext12(inst[31:20]);
                dec_legal = 1'b1;
                case (funct3)
                    3'b000: dec_op = OP_ADD;
                    3'b010: dec_op = OP_SLT;
                    3'b011: dec_op = OP_SLTU;
                    3'b100: dec_op = OP_XOR;
                    3'b110: dec_op = OP_OR;
                    3'b111: dec_op = OP_AND;
                    3'b001: begin
                        dec_rs2 = {{(XLEN-5){1'b0}}, inst[24:20]};
                        if (funct7 == F7_BASE) begin
                            dec_op = OP_SLL;
                        end else begin
                            dec_legal = 1'b0;
                        end
                    end
                    3'b101: begin
                        dec_rs2 = {{(XLEN-5){1'b0}}, inst[24:20]};
                        if (funct7 == F7_BASE) begin
                            dec_op = OP_SRL;
                        end else if (funct7 == F7_ALT) begin
                            dec_op = OP_SRA;
                        end else begin
                            dec_legal = 1'b0;
                        end
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                dec_legal  = 1'b1;
                dec_op     = OP_LUI;
                dec_bitimm = inst[31:12];
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign dec_rs2_m = is_shift(dec_op) ? mask_shamt(dec_rs2) : dec_rs2;

    assign inst_ready = (state == S_IDLE) && rst_n;

    // Result is only reported while the datapath output is valid (WB).
    assign retire_data = retire_valid ? dp_rd : '0;

    assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];

    // -----------------------------------------------------------------------
    // Control FSM with registered datapath/retire outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            dp_op          <= IDLE_OP;
            dp_rs1         <= '0;
            dp_rs2         <= '0;
            dp_bitimm      <= '0;
            wb_addr_p1     <= '0;
            addsub_p1      <= 1'b0;
            retire_valid   <= 1'b0;
            retire_rd_addr <= '0;
            illegal        <= 1'b0;
            ovf_sticky     <= 1'b0;
        end else begin
            illegal      <= 1'b0;
            retire_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (inst_valid) begin
                        if (dec_legal) begin
                            dp_op      <= dec_op;
                            dp_rs1     <= dec_rs1;
                            dp_rs2     <= dec_rs2_m;
                            dp_bitimm  <= dec_bitimm;
                            wb_addr_p1 <= inst[11:7];
                            addsub_p1  <= (dec_op == OP_ADD) || (dec_op == OP_SUB);
                            state      <= S_EXEC;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    // Datapath captures the operands at this edge.
                    dp_op          <= IDLE_OP;
                    retire_valid   <= 1'b1;
                    retire_rd_addr <= wb_addr_p1;
                    state          <= S_WB;
                end
                S_WB: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // A carry set in WB takes priority over a simultaneous clear.
            if ((state == S_WB) && addsub_p1 && dp_overflow) begin
                ovf_sticky <= 1'b1;
            end else if (ovf_clr) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Register-file write-back at the closing edge of WB
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if ((state == S_WB) && (wb_addr_p1 != 5'd0)) begin
            rf[wb_addr_p1] <= dp_rd;
        end
    end

endmodule
